fir_decim_mc: RTL

FIR_DECIM_MC -- requirements
Module: fir_decim_mc

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_mac_lane.sv | 52 +++++
 rtl/fir_decim_mc.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared FSM encoding and output quantizer for the multi-channel decimating FIR.
package fir_pkg;

    typedef enum logic [1:0] {SHIFT, MAC, OUT} state_t;

    // Wide enough for any accumulator the filter can instantiate (2*DATA_WIDTH <= QUANT_W).
    localparam int QUANT_W = 128;

    function automatic logic signed [QUANT_W-1:0] quantize(
        input logic signed [QUANT_W-1:0] acc,
        input int                        frac_bits
    );
        return acc >>> frac_bits;
    endfunction

endpackage

// File: rtl/fir_mac_lane.sv
// One channel's MAC datapath: parallel multipliers, adder tree, registered partial sum, wrapping accumulator.
module fir_mac_lane #(
    parameter int DATA_WIDTH     = 32,
    parameter int MULT_PER_CYCLE = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           issue,
    input  logic signed [DATA_WIDTH-1:0]   samples [MULT_PER_CYCLE],
    input  logic signed [DATA_WIDTH-1:0]   coefs   [MULT_PER_CYCLE],
    output logic signed [2*DATA_WIDTH-1:0] acc
);

    localparam int ACC_W = 2 * DATA_WIDTH;

    logic signed [ACC_W-1:0] tree_sum;
    logic signed [ACC_W-1:0] sum_p1;
    logic                    vld_p1;

    always_comb begin
        tree_sum = '0;
        for (int j = 0; j < MULT_PER_CYCLE; j++) begin
            tree_sum = tree_sum + ACC_W'(samples[j]) * ACC_W'(coefs[j]);
        end
    end

    // Stage p1: partial sum of this tap group, qualified by vld_p1.
    always_ff @(posedge clock) begin
        sum_p1 <= tree_sum;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= issue;
        end
    end

    // Accumulate stage: wraps modulo 2^ACC_W.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (vld_p1) begin
            acc <= acc + sum_p1;
        end
    end

endmodule

// File: rtl/fir_decim_mc.sv
// Multi-channel decimating FIR: shared taps, sliding delay lines, time-multiplexed MAC over tap groups.
module fir_decim_mc
    import fir_pkg::*;
#(
    parameter int TAP_COUNT      = 32,
    parameter int DECIMATION     = 8,
    parameter int MULT_PER_CYCLE = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int CHANNELS       = 2,
    parameter int FRAC_BITS      = 10
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [CHANNELS-1:0][DATA_WIDTH-1:0]  in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [TAP_COUNT-1:0][DATA_WIDTH-1:0] taps,
    output logic [CHANNELS-1:0][DATA_WIDTH-1:0]  out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready
);

    localparam int GROUPS = TAP_COUNT / MULT_PER_CYCLE;
    localparam int CNT_W  = $clog2(DECIMATION + 1);
    localparam int K_W    = $clog2(GROUPS + 1);
    localparam int IDX_W  = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1;

    if (TAP_COUNT % MULT_PER_CYCLE != 0 || DECIMATION < 1 || 2 * DATA_WIDTH > QUANT_W) begin : g_param_check
        $error("fir_decim_mc: illegal parameter combination");
    end

    state_t                  state, next_state;
    logic [CNT_W-1:0]        count;
    logic [K_W-1:0]          k;
    logic                    accept, last, issue;
    logic signed [DATA_WIDTH-1:0]   delay   [CHANNELS][TAP_COUNT];
    logic signed [DATA_WIDTH-1:0]   samples [CHANNELS][MULT_PER_CYCLE];
    logic signed [DATA_WIDTH-1:0]   coefs   [MULT_PER_CYCLE];
    logic signed [2*DATA_WIDTH-1:0] lane_acc [CHANNELS];

    assign in_ready  = (state == SHIFT);
    assign out_valid = (state == OUT);
    assign accept    = in_valid && in_ready;
    assign last      = accept && (count == CNT_W'(DECIMATION - 1));
    // k runs one past the last group so the lane's registered partial sum drains before OUT.
    assign issue     = (state == MAC) && (k < K_W'(GROUPS));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SHIFT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            SHIFT:   if (last) next_state = MAC;
            MAC:     if (k == K_W'(GROUPS)) next_state = OUT;
            OUT:     if (out_ready) next_state = SHIFT;
            default: next_state = SHIFT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            k     <= '0;
        end else begin
            if (accept) begin
                count <= last ? '0 : count + CNT_W'(1);
            end
            k <= (state == MAC) ? k + K_W'(1) : '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int i = 0; i < TAP_COUNT; i++) begin
                    delay[c][i] <= '0;
                end
            end
        end else if (accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                delay[c][0] <= in_data[c];
                for (int i = 1; i < TAP_COUNT; i++) begin
                    delay[c][i] <= delay[c][i-1];
                end
            end
        end
    end

    always_comb begin
        int grp;
        logic [IDX_W-1:0] idx;
        grp = issue ? int'(k) : 0;
        idx = '0;
        for (int j = 0; j < MULT_PER_CYCLE; j++) begin
            idx      = IDX_W'(grp * MULT_PER_CYCLE + j);
            coefs[j] = taps[idx];
            for (int c = 0; c < CHANNELS; c++) begin
                samples[c][j] = delay[c][idx];
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        fir_mac_lane #(
            .DATA_WIDTH     (DATA_WIDTH),
            .MULT_PER_CYCLE (MULT_PER_CYCLE)
        ) u_lane (
            .clock   (clock),
            .reset   (reset),
            .clear   (last),
            .issue   (issue),
            .samples (samples[c]),
            .coefs   (coefs),
            .acc     (lane_acc[c])
        );

        assign out_data[c] = DATA_WIDTH'(quantize(QUANT_W'(lane_acc[c]), FRAC_BITS));
    end

endmodule
